// File: rtl/bcd_seg_display_if.sv
// Handshake and data bundle between a requester and bcd_seg_display.
// The requester (master) drives load/value/blank_lz; the converter (slave)
// returns busy/valid/overflow and the registered segment patterns.
interface bcd_seg_display_if #(
  parameter int DIGITS   = 2,
  parameter int IN_WIDTH = 32
);
  logic                  load;
  logic [IN_WIDTH-1:0]   value;
  logic                  blank_lz;
  logic                  busy;
  logic                  valid;
  logic                  overflow;
  logic [7*DIGITS-1:0]   segs;

  modport master (
    output load, value, blank_lz,
    input  busy, valid, overflow, segs
  );

  modport slave (
    input  load, value, blank_lz,
    output busy, valid, overflow, segs
  );
endinterface

// File: rtl/bcd_seg_display.sv
// Binary to multi-digit seven-segment converter.
// A load in IDLE captures the value, then CONV runs one double-dabble step per
// cycle (MSB first) for IN_WIDTH cycles, and UPDATE registers the decoded
// active-low segment patterns together with an overflow flag and a valid pulse.
module bcd_seg_display #(
  parameter int DIGITS   = 2,
  parameter int IN_WIDTH = 32
) (
  input  logic              clock,
  input  logic              resetn,
  bcd_seg_display_if.slave  bus
);

  // Enough nibbles that no intermediate double-dabble result is truncated.
  localparam int NIB = (IN_WIDTH + 2) / 3 + 1;
  localparam int AW  = NIB * 4;
  localparam int SW  = 7 * DIGITS;
  localparam int CW  = $clog2(IN_WIDTH + 1);

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [IN_WIDTH-1:0] shreg_q;
  logic [AW-1:0]       acc_q;
  logic                blank_q;
  logic [SW-1:0]       segs_q;
  logic                ovf_q;
  logic                valid_q;

  logic                capture_en, shift_en, update_en, busy;
  logic                last_shift;
  logic [AW-1:0]       acc_adj;
  logic [AW-1:0]       acc_shift;
  logic [DIGITS*4-1:0] dig_w;
  logic [NIB-1:0]      hi_nz;
  logic                ovf_d;
  logic [SW-1:0]       segs_d;

  // Active-low gfedcba pattern of one BCD digit; non-BCD codes show blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign last_shift = (cnt_q == CW'(IN_WIDTH - 1));

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: loads are only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.load) state_d = CONV;
      CONV:    if (last_shift) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/control decode from the current state only.
  always_comb begin
    busy       = (state_q != IDLE);
    capture_en = (state_q == IDLE) && bus.load;
    shift_en   = (state_q == CONV);
    update_en  = (state_q == UPDATE);
  end

  // Add-3 correction on every nibble, then shift in the next input bit.
  for (genvar gi = 0; gi < NIB; gi++) begin : g_adj
    assign acc_adj[gi*4 +: 4] = (acc_q[gi*4 +: 4] >= 4'd5) ?
                                (acc_q[gi*4 +: 4] + 4'd3) : acc_q[gi*4 +: 4];
  end
  assign acc_shift = (acc_adj << 1) | {{(AW-1){1'b0}}, shreg_q[IN_WIDTH-1]};

  // Displayed digits; digits beyond the accumulator width read as zero.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
    if (gi < NIB) begin : g_in
      assign dig_w[gi*4 +: 4] = acc_q[gi*4 +: 4];
    end else begin : g_out
      assign dig_w[gi*4 +: 4] = 4'd0;
    end
  end

  // Any nonzero nibble above the displayed digits means overflow.
  for (genvar gi = 0; gi < NIB; gi++) begin : g_hi
    if (gi >= DIGITS) begin : g_chk
      assign hi_nz[gi] = |acc_q[gi*4 +: 4];
    end else begin : g_low
      assign hi_nz[gi] = 1'b0;
    end
  end
  assign ovf_d = |hi_nz;

  // Per-digit pattern: dash on overflow, blank for suppressed leading zeros.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
    if (gi == 0) begin : g_lsd
      assign segs_d[6:0] = ovf_d ? SEG_DASH : seg7(dig_w[3:0]);
    end else begin : g_upper
      logic zero_above;
      assign zero_above = ~|dig_w[DIGITS*4-1 : gi*4];
      assign segs_d[gi*7 +: 7] = ovf_d ? SEG_DASH :
                                 (blank_q && zero_above) ? SEG_BLANK :
                                 seg7(dig_w[gi*4 +: 4]);
    end
  end

  // Datapath: capture, conversion steps and result registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      acc_q   <= '0;
      blank_q <= 1'b0;
      segs_q  <= '1;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (capture_en) begin
        shreg_q <= bus.value;
        blank_q <= bus.blank_lz;
        acc_q   <= '0;
        cnt_q   <= '0;
      end
      if (shift_en) begin
        shreg_q <= shreg_q << 1;
        acc_q   <= acc_shift;
        cnt_q   <= cnt_q + CW'(1);
      end
      if (update_en) begin
        segs_q  <= segs_d;
        ovf_q   <= ovf_d;
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.valid    = valid_q;
  assign bus.overflow = ovf_q;
  assign bus.segs     = segs_q;

endmodule

// File: doc/bcd_seg_display.md
BCD_SEG_DISPLAY -- requirements
Module: bcd_seg_display

Interface
REQ-001 Parameter DIGITS, default 2, number of seven-segment digits driven; legal range 1..8.
REQ-002 Parameter IN_WIDTH, default 32, width of the binary input value; legal range 4..32.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 load  input  1  request to start converting value; sampled on a rising clock edge.
REQ-006 value  input  IN_WIDTH  unsigned binary number to display.
REQ-007 blank_lz  input  1  leading-zero blanking enable; captured with value on an accepted load.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 valid  output  1  one-cycle pulse on the cycle segs and overflow take a new result.
REQ-010 overflow  output  1  held high while the displayed result exceeds 10^DIGITS-1.
REQ-011 segs  output  7*DIGITS  registered active-low segment patterns; bits [6:0] are digit 0 (least significant); bit order within each digit is g,f,e,d,c,b,a at bits 6..0.

Function
REQ-012 The FSM SHALL have states IDLE, CONV and UPDATE.
REQ-013 In IDLE with load=1, the block SHALL capture value and blank_lz, clear the internal BCD accumulator, assert busy, and enter CONV.
REQ-014 CONV SHALL run exactly IN_WIDTH cycles of shift-and-add-3 (double dabble), one input bit per cycle, MSB first, using a cycle counter.
REQ-015 Before each shift, every BCD nibble >= 5 SHALL have 3 added; the accumulator SHALL hold ceil(IN_WIDTH/3)+1 nibbles so no intermediate result is lost.
REQ-016 After the last shift the FSM SHALL enter UPDATE, write segs and overflow, pulse valid for one cycle, deassert busy, and return to IDLE.
REQ-017 Latency: for a load accepted at edge k, segs/overflow/valid SHALL update at edge k+IN_WIDTH+1; busy is high from edge k to edge k+IN_WIDTH+1, exclusive.
REQ-018 A load asserted while busy=1 SHALL be ignored, with no queuing; a load in the same cycle as UPDATE is also ignored.
REQ-019 Digit encoding (gfe_dcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-020 Overflow: if any BCD nibble at index >= DIGITS is nonzero, overflow SHALL be 1 and every digit SHALL show dash 0111111; otherwise overflow SHALL be 0.
REQ-021 With captured blank_lz=1 and no overflow, each zero digit above the most significant nonzero digit SHALL show 1111111; digit 0 SHALL always be shown, so value 0 displays "0".
REQ-022 With captured blank_lz=0, all DIGITS digits SHALL be shown, including leading zeros.
REQ-023 segs and overflow SHALL hold their last result through subsequent IDLE and CONV cycles until the next UPDATE.
REQ-024 Outputs SHALL depend only on registered state; there is no combinational path from inputs to outputs.

Reset
REQ-025 While resetn=0, the block SHALL immediately force these values: state=IDLE, busy=0, valid=0, overflow=0, segs all 1s (blank), counter and accumulator 0.
REQ-026 A reset asserted mid-conversion SHALL abort it with no valid pulse; the first load after resetn rises starts a fresh conversion.

Verification (DIGITS=2, IN_WIDTH=32 unless stated)
REQ-027 Reset release, no load -> segs=14'h3FFF, busy=0, valid=0, overflow=0 indefinitely.
REQ-028 load=1 with value=42, blank_lz=0 -> busy for 33 cycles, then valid pulse, segs=0011001_0100100, overflow=0.
REQ-029 value=7 with blank_lz=1 -> segs=1111111_1111000; with blank_lz=0 -> segs=1000000_1111000; and value=0 with blank_lz=1 -> segs=1111111_1000000.
REQ-030 value=100 -> overflow=1, segs=0111111_0111111; a following load with value=99 -> overflow=0, segs=0010000_0010000.
REQ-031 load with value=55, then load with value=12 pulsed at cycle 10 of the conversion -> the second load is ignored, the result shows 55, and only one valid pulse occurs.
REQ-032 resetn pulsed low at cycle 20 of the conversion -> busy=0 and segs blank at once, no valid pulse; a new load with value=3 gives segs=1000000_0110000 after 33 cycles; DIGITS=8 with value=32'hFFFFFFFF -> overflow=1.
